// File: rtl/ccx_ic_arb2_if.sv
// Request/response bus shared by both requesters and the shared memory target.
interface ccx_ic_arb2_if #(
  parameter int unsigned AW = 39,
  parameter int unsigned DW = 64
);
  localparam int unsigned SW = DW / 8;

  logic          req;
  logic [AW-1:0] addr;
  logic          wen;
  logic [SW-1:0] strb;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          err;
  logic [DW-1:0] rdata;

  // Requester side: drives the request payload, receives grant and response.
  modport master (
    output req, addr, wen, strb, wdata,
    input  gnt, err, rdata
  );

  // Target side: receives the request payload, drives grant and response.
  modport slave (
    input  req, addr, wen, strb, wdata,
    output gnt, err, rdata
  );
endinterface

// File: rtl/ccx_ic_arb2.sv
// Two-requester arbiter in front of one shared memory target.
// m0 (data port) has fixed priority; m1 (instruction port) is promoted after
// STARVE_LIMIT lost cycles. A stalled request keeps ownership until accepted,
// and each one-cycle-delayed response is routed back to its issuer.
module ccx_ic_arb2 #(
  parameter int unsigned AW           = 39,
  parameter int unsigned DW           = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  ccx_ic_arb2_if.slave  m0,
  ccx_ic_arb2_if.slave  m1,
  ccx_ic_arb2_if.master s
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  logic          lock_vld_q, lock_vld_d;
  logic          lock_id_q,  lock_id_d;
  logic          rsp_vld_q,  rsp_vld_d;
  logic          rsp_id_q,   rsp_id_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  logic          sel_c;
  logic          s_req_c;
  logic          m0_gnt_c;
  logic          m1_gnt_c;
  logic          rsp0_c;
  logic          rsp1_c;
  logic [AW-1:0] s_addr_c;
  logic          s_wen_c;
  logic [SW-1:0] s_strb_c;
  logic [DW-1:0] s_wdata_c;

  // Owner selection: live lock first, then sole requester, then priority/starvation.
  always_comb begin
    sel_c = 1'b0;
    if (lock_vld_q && (lock_id_q ? m1.req : m0.req)) begin
      sel_c = lock_id_q;
    end else if (m0.req && m1.req) begin
      sel_c = (starve_cnt_q == CNT_MAX);
    end else if (m1.req) begin
      sel_c = 1'b1;
    end
  end

  // Forward the selected request; grant goes only to the owner, nothing during reset.
  always_comb begin
    s_req_c   = g_resetn && (sel_c ? m1.req : m0.req);
    s_addr_c  = sel_c ? m1.addr  : m0.addr;
    s_wen_c   = sel_c ? m1.wen   : m0.wen;
    s_strb_c  = sel_c ? m1.strb  : m0.strb;
    s_wdata_c = sel_c ? m1.wdata : m0.wdata;
    m0_gnt_c  = s_req_c && s.gnt && !sel_c;
    m1_gnt_c  = s_req_c && s.gnt &&  sel_c;
    rsp0_c    = g_resetn && rsp_vld_q && !rsp_id_q;
    rsp1_c    = g_resetn && rsp_vld_q &&  rsp_id_q;
  end

  assign s.req    = s_req_c;
  assign s.addr   = s_addr_c;
  assign s.wen    = s_wen_c;
  assign s.strb   = s_strb_c;
  assign s.wdata  = s_wdata_c;
  assign m0.gnt   = m0_gnt_c;
  assign m1.gnt   = m1_gnt_c;
  assign m0.err   = rsp0_c && s.err;
  assign m1.err   = rsp1_c && s.err;
  assign m0.rdata = rsp0_c ? s.rdata : '0;
  assign m1.rdata = rsp1_c ? s.rdata : '0;

  // Next state for lock, response owner and m1 starvation counter.
  always_comb begin
    lock_vld_d   = s_req_c && !s.gnt;
    lock_id_d    = sel_c;
    rsp_vld_d    = s_req_c && s.gnt;
    rsp_id_d     = sel_c;
    starve_cnt_d = starve_cnt_q;
    if (!m1.req || m1_gnt_c) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      lock_vld_q   <= 1'b0;
      lock_id_q    <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      lock_vld_q   <= lock_vld_d;
      lock_id_q    <= lock_id_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_id_q     <= rsp_id_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_ccx_ic_arb2.sv
// Self-checking bench for ccx_ic_arb2: per-cycle grant/forwarding checks and a
// response scoreboard filled at accept time and drained one cycle later.
module tb_ccx_ic_arb2;

  localparam int unsigned AW = 39;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  typedef struct packed {
    logic          id;
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  logic g_clk;
  logic g_resetn;

  ccx_ic_arb2_if #(.AW(AW), .DW(DW)) m0 ();
  ccx_ic_arb2_if #(.AW(AW), .DW(DW)) m1 ();
  ccx_ic_arb2_if #(.AW(AW), .DW(DW)) s ();

  ccx_ic_arb2 #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .m0       (m0),
    .m1       (m1),
    .s        (s)
  );

  int            checks;
  int            errors;
  rsp_t          sb_q[$];
  logic [DW-1:0] cur_rdata;
  logic [DW-1:0] nxt_rdata;
  logic          cur_err;
  logic          nxt_err;

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  task automatic roll_rsp();
    cur_rdata = nxt_rdata;
    cur_err   = nxt_err;
    nxt_rdata = {$urandom, $urandom};
    nxt_err   = 1'($urandom_range(0, 1));
  endtask

  task automatic set_payload(input logic wen0, input logic wen1);
    m0.addr  = AW'({$urandom, $urandom});
    m0.wen   = wen0;
    m0.strb  = SW'($urandom);
    m0.wdata = {$urandom, $urandom};
    m1.addr  = AW'({$urandom, $urandom});
    m1.wen   = wen1;
    m1.strb  = SW'($urandom);
    m1.wdata = {$urandom, $urandom};
  endtask

  // One functional cycle. es: -1 = no target request expected, 0/1 = owner forwarded.
  task automatic cyc(input string nm, input logic r0, input logic r1, input logic sg,
                     input logic eg0, input logic eg1, input int es);
    rsp_t          r;
    logic          e_err0, e_err1;
    logic [DW-1:0] e_rd0, e_rd1;
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    m0.req   = r0;
    m1.req   = r1;
    s.gnt    = sg;
    s.rdata  = cur_rdata;
    s.err    = cur_err;
    #3;
    checks++;
    if (m0.gnt !== eg0) begin
      errors++;
      $display("FAIL %s m0_gnt got %0b exp %0b", nm, m0.gnt, eg0);
    end
    checks++;
    if (m1.gnt !== eg1) begin
      errors++;
      $display("FAIL %s m1_gnt got %0b exp %0b", nm, m1.gnt, eg1);
    end
    checks++;
    if (s.req !== (es >= 0)) begin
      errors++;
      $display("FAIL %s s_req got %0b exp %0b", nm, s.req, (es >= 0));
    end
    if (es >= 0) begin
      checks++;
      if ({s.addr, s.wen, s.strb, s.wdata} !==
          ((es == 1) ? {m1.addr, m1.wen, m1.strb, m1.wdata} : {m0.addr, m0.wen, m0.strb, m0.wdata})) begin
        errors++;
        $display("FAIL %s s_payload got addr %h wen %0b strb %h wdata %h exp owner m%0d",
                 nm, s.addr, s.wen, s.strb, s.wdata, es);
      end
    end
    e_err0 = 1'b0; e_err1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      if (r.id) begin e_err1 = r.err; e_rd1 = r.rdata; end
      else      begin e_err0 = r.err; e_rd0 = r.rdata; end
    end
    checks++;
    if (m0.err !== e_err0 || m0.rdata !== e_rd0) begin
      errors++;
      $display("FAIL %s m0_rsp got err %0b rdata %h exp err %0b rdata %h", nm, m0.err, m0.rdata, e_err0, e_rd0);
    end
    checks++;
    if (m1.err !== e_err1 || m1.rdata !== e_rd1) begin
      errors++;
      $display("FAIL %s m1_rsp got err %0b rdata %h exp err %0b rdata %h", nm, m1.err, m1.rdata, e_err1, e_rd1);
    end
    if (eg0 || eg1) begin
      r.id    = eg1;
      r.err   = nxt_err;
      r.rdata = nxt_rdata;
      sb_q.push_back(r);
    end
    roll_rsp();
  endtask

  // One cycle with reset held low: everything visible must be quiet, pending responses dropped.
  task automatic rst_cyc(input string nm, input logic r0, input logic r1, input logic sg);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b0;
    m0.req   = r0;
    m1.req   = r1;
    s.gnt    = sg;
    s.rdata  = cur_rdata;
    s.err    = 1'b1;
    #3;
    checks++;
    if ({s.req, m0.gnt, m1.gnt} !== 3'b000) begin
      errors++;
      $display("FAIL %s rst_gnt got s_req %0b m0_gnt %0b m1_gnt %0b exp 0", nm, s.req, m0.gnt, m1.gnt);
    end
    checks++;
    if ({m0.err, m1.err} !== 2'b00 || m0.rdata !== '0 || m1.rdata !== '0) begin
      errors++;
      $display("FAIL %s rst_rsp got m0 %0b/%h m1 %0b/%h exp 0", nm, m0.err, m0.rdata, m1.err, m1.rdata);
    end
    sb_q.delete();
    roll_rsp();
  endtask

  task automatic test_reset();
    set_payload(1'b0, 1'b0);
    rst_cyc("reset0", 1'b1, 1'b1, 1'b1);
    rst_cyc("reset1", 1'b1, 1'b1, 1'b1);
    cyc("reset_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_single_m1();
    set_payload(1'b0, 1'b0);
    m1.addr   = AW'(39'h100);
    nxt_rdata = 64'hDEADBEEF_00000001;
    cyc("single_acc", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    cyc("single_rsp", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_starvation();
    set_payload(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc("starve", 1'b1, 1'b1, 1'b1, (i % 5) != 4, (i % 5) == 4, ((i % 5) == 4) ? 1 : 0);
    end
    cyc("starve_drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_lock();
    set_payload(1'b0, 1'b1);
    cyc("lock_c0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    cyc("lock_c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    cyc("lock_c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    cyc("lock_c3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    cyc("lock_c4", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    cyc("lock_drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    set_payload(1'b0, 1'b0);
    nxt_err = 1'b1;
    cyc("b2b_m0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    nxt_err = 1'b0;
    cyc("b2b_m1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    cyc("b2b_drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    set_payload(1'b0, 1'b0);
    nxt_rdata = 64'h55;
    nxt_err   = 1'b1;
    cyc("mid_acc", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    rst_cyc("mid_rst", 1'b0, 1'b0, 1'b0);
    cyc("mid_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    // Leave a stalled m1 lock and a nonzero starve count behind, then reset.
    cyc("mid_lock", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    cyc("mid_lock2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    rst_cyc("mid_rst2", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc("post_rst", 1'b1, 1'b1, 1'b1, i != 4, i == 4, (i == 4) ? 1 : 0);
    end
    cyc("post_drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_write();
    set_payload(1'b1, 1'b0);
    m0.strb = 8'h0F;
    nxt_err = 1'b1;
    cyc("write_acc", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    nxt_err = 1'b0;
    cyc("write_acc2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    cyc("write_drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    g_resetn  = 1'b0;
    m0.req    = 1'b0;
    m1.req    = 1'b0;
    s.gnt     = 1'b0;
    s.err     = 1'b0;
    s.rdata   = '0;
    set_payload(1'b0, 1'b0);
    nxt_rdata = {$urandom, $urandom};
    nxt_err   = 1'b0;
    roll_rsp();

    test_reset();
    test_single_m1();
    test_starvation();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    test_write();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
